// File: rtl/screen_fade_ctrl_if.sv
// Pixel, game-logic and VGA output signals of the screen fade controller.
// master = game/video side driving the controller, slave = the controller itself.
interface screen_fade_ctrl_if;
    logic [9:0] DrawX, DrawY;
    logic       blank;
    logic       game_over;
    logic       key_restart;
    logic       restart_ack;
    logic [3:0] board_red, board_green, board_blue;
    logic [3:0] end_red, end_green, end_blue;
    logic [3:0] red, green, blue;
    logic       restart_req;
    logic [1:0] mode;

    modport master (
        output DrawX, DrawY, blank, game_over, key_restart, restart_ack,
               board_red, board_green, board_blue, end_red, end_green, end_blue,
        input  red, green, blue, restart_req, mode
    );
    modport slave (
        input  DrawX, DrawY, blank, game_over, key_restart, restart_ack,
               board_red, board_green, board_blue, end_red, end_green, end_blue,
        output red, green, blue, restart_req, mode
    );
endinterface

// File: rtl/screen_fade_ctrl.sv
// Board <-> endgame display sequencer with frame-locked cross-fade and restart handshake.
// SCREEN_FADE_EN selects the gradual blend; undefined gives a hard cut at lvl 16.
module screen_fade_ctrl #(
    parameter int FADE_DIV    = 2,
    parameter int HOLD_FRAMES = 60
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    screen_fade_ctrl_if.slave bus
);
    localparam int DW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [2:0] {PLAY, FADE_OUT, HOLD, RESTART, FADE_IN} state_t;

    state_t        state, state_n;
    logic [DW-1:0] div_cnt;
    logic [HW-1:0] hold_cnt;
    logic [4:0]    pos;
    logic [4:0]    lvl;
    logic          key_q;
    logic          tick, fading, div_wrap, step, key_rise, hold_done;
    logic [3:0]    red_q, green_q, blue_q;

    assign tick      = (bus.DrawX == 10'd639) && (bus.DrawY == 10'd479);
    assign fading    = (state == FADE_OUT) || (state == FADE_IN);
    assign div_wrap  = (div_cnt == DW'(FADE_DIV - 1));
    assign step      = tick && fading && div_wrap;
    assign key_rise  = bus.key_restart && !key_q;
    assign hold_done = (hold_cnt == HW'(HOLD_FRAMES));

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) state <= PLAY;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            PLAY:     if (bus.game_over) state_n = FADE_OUT;
            FADE_OUT: if (step && pos == 5'd15) state_n = HOLD;
            HOLD:     if (key_rise && hold_done) state_n = RESTART;
            RESTART:  if (bus.restart_ack) state_n = FADE_IN;
            FADE_IN: begin
                if (bus.game_over)              state_n = FADE_OUT;
                else if (step && pos == 5'd1)   state_n = PLAY;
            end
            default:  state_n = PLAY;
        endcase
    end

    // pos tracks fade progress in both builds so FSM timing never depends on the blend option
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            hold_cnt <= '0;
            pos      <= '0;
            key_q    <= 1'b0;
        end else begin
            key_q <= bus.key_restart;
            if (!fading)   div_cnt <= '0;
            else if (tick) div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (state != HOLD)           hold_cnt <= '0;
            else if (tick && !hold_done) hold_cnt <= hold_cnt + 1'b1;
            if (step) pos <= (state == FADE_OUT || bus.game_over) ? pos + 5'd1 : pos - 5'd1;
        end
    end

`ifdef SCREEN_FADE_EN
    assign lvl = pos;

    function automatic logic [3:0] mix(input logic [3:0] b, input logic [3:0] e, input logic [4:0] l);
        logic [7:0] sum;
        sum = 8'(b) * 8'(5'd16 - l) + 8'(e) * 8'(l);
        return sum[7:4];
    endfunction
`else
    // hard cut: the displayed level jumps on the first tick of each fade
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n)                      lvl <= '0;
        else if (tick && state == FADE_OUT) lvl <= 5'd16;
        else if (tick && state == FADE_IN)  lvl <= 5'd0;
    end

    function automatic logic [3:0] mix(input logic [3:0] b, input logic [3:0] e, input logic [4:0] l);
        return (l == 5'd16) ? e : b;
    endfunction
`endif

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else if (bus.blank) begin
            red_q   <= mix(bus.board_red,   bus.end_red,   lvl);
            green_q <= mix(bus.board_green, bus.end_green, lvl);
            blue_q  <= mix(bus.board_blue,  bus.end_blue,  lvl);
        end else begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end
    end

    assign bus.red         = red_q;
    assign bus.green       = green_q;
    assign bus.blue        = blue_q;
    assign bus.restart_req = (state == RESTART);

    always_comb begin
        bus.mode = 2'd0;
        case (state)
            FADE_OUT:      bus.mode = 2'd1;
            HOLD, RESTART: bus.mode = 2'd2;
            FADE_IN:       bus.mode = 2'd3;
            default:       bus.mode = 2'd0;
        endcase
    end
endmodule

// File: doc/screen_fade_ctrl.md
# screen_fade_ctrl

Display-mode controller that sequences the VGA output between the live 2048 board renderer and the full-screen endgame sprite. On game-over it cross-fades the board into the endgame image, holds it for a minimum time, waits for a restart key, handshakes a board reset with the game logic, then fades back. It sits between the two pixel sources and the VGA output registers, in the vga_clk domain.

## Interface
- FADE_DIV, 2: frames per fade step (≥1)
- HOLD_FRAMES, 60: minimum frames the endgame image is shown before restart is accepted (≥1)
- vga_clk  in  1  pixel clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- DrawX, DrawY  in  10 each  current pixel coordinate from the VGA controller
- blank  in  1  display-enable, high = visible pixel
- game_over  in  1  level from game logic, high = no moves left
- key_restart  in  1  synchronized restart key level
- board_red, board_green, board_blue  in  4 each  board renderer pixel
- end_red, end_green, end_blue  in  4 each  endgame palette pixel
- restart_ack  in  1  game logic has reset the board
- red, green, blue  out  4 each  registered VGA pixel
- restart_req  out  1  request board reset
- mode  out  2  current state encoding (PLAY=0, FADE_OUT=1, HOLD=2, FADE_IN=3; RESTART reported as 2)

## Operation
- Frame tick: single-cycle internal pulse on the cycle DrawX==639 && DrawY==479. Level and frame counters change only on a tick, so no mid-frame tearing.
- Fade level lvl: 5 bits, 0..16. Blend per channel: out = (board*(16−lvl) + end*lvl) >> 4. Products ≤ 240, held in 8-bit sums, with the result truncated to 4 bits. lvl=0 gives pure board, lvl=16 gives pure endgame.
- Step counter: counts ticks modulo FADE_DIV and produces a step pulse when it wraps.
- States:
  - PLAY: lvl=0. A high game_over moves the FSM to FADE_OUT.
  - FADE_OUT: lvl+1 per step. When lvl reaches 16, move to HOLD and clear the hold counter.
  - HOLD: the hold counter increments per tick, saturating at HOLD_FRAMES. A rising edge of key_restart is accepted only when the counter equals HOLD_FRAMES, and moves the FSM to RESTART. Earlier edges are discarded.
  - RESTART: restart_req=1. While restart_ack is low, remain in RESTART. When restart_ack is sampled high, drop restart_req and move to FADE_IN.
  - FADE_IN: lvl−1 per step. When lvl reaches 0, move to PLAY.
- Simultaneous events:
  - If game_over is high during FADE_IN, the FSM reverses to FADE_OUT from the current lvl without a jump.
  - restart_ack outside RESTART is ignored.
  - key_restart is ignored outside HOLD.
- Reset (asynchronous, at any point including mid-fade or mid-handshake): state=PLAY, lvl=0, all counters 0, key edge register 0, restart_req=0, red/green/blue=0, mode=0.

## Timing
- Pixel path latency is 1 cycle: the output on posedge N+1 reflects the inputs sampled at posedge N, using the lvl in effect at N. When blank=0, the output is 0 at N+1.
- Full fade takes 16*FADE_DIV frames. A lvl update takes effect on the cycle after the tick.
- restart_req rises 1 cycle after the accepted key edge. It falls on the cycle after restart_ack is sampled high. FADE_IN is entered on that same cycle.
- The game_over → FADE_OUT transition occurs on the first posedge where game_over is sampled high in PLAY. It does not wait for a tick.

## Configuration
- SCREEN_FADE_EN defined: gradual blend as specified.
- SCREEN_FADE_EN undefined:
  - No multipliers.
  - FADE_OUT sets lvl=16 and FADE_IN sets lvl=0 on the next tick, with FSM timing otherwise unchanged.
  - The output mux selects board when lvl<16 and endgame when lvl=16.

## Test plan
- Reset, then PLAY with board=0x123 and end=0xFED, blank=1 → output 0x123 one cycle later, mode=0, restart_req=0.
- game_over high, FADE_DIV=2 → lvl reaches 8 after 16 frame ticks. At board r=0, end r=15, red=(15*8)>>4=7. mode=2 after 32 ticks.
- key_restart edge at HOLD tick 10 (HOLD_FRAMES=60) → ignored. Edge after 60 ticks → restart_req=1 on the next cycle.
- restart_ack delayed 5 cycles → restart_req stays high for 5 cycles, drops the cycle after ack, mode=3. Then 32 ticks to PLAY.
- game_over reasserted during FADE_IN at lvl=9 → mode=1, with lvl continuing 10, 11… and no jump. Separately, reset_n low mid-RESTART → restart_req=0 and outputs 0 immediately.
- blank=0 in any state → red/green/blue=0 one cycle later. With SCREEN_FADE_EN undefined → output is pure end colour exactly one tick after FADE_OUT entry.
